// File: rtl/ace_bus_master.sv
// ace_bus_master: line-transaction engine between the cache controller request
// interface and the coherent interconnect port (read fill, writeback, CleanUnique).
// Optional build macro: BUS_TIMEOUT_EN enables a response-wait timeout of
// TIMEOUT_CYCLES cycles; without it the block waits on the bus indefinitely.
module ace_bus_master #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int LINE_WORDS     = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             read_req,
    input  logic                             write_req,
    input  logic                             invalid_req,
    input  logic [ADDR_WIDTH-1:0]            req_addr,
    input  logic [LINE_WORDS*DATA_WIDTH-1:0] wb_line,
    output logic [LINE_WORDS*DATA_WIDTH-1:0] rd_line,
    output logic                             ace_ready,
    output logic                             resp_err,
    output logic                             bus_req_valid,
    input  logic                             bus_req_ready,
    output logic [1:0]                       bus_req_op,
    output logic [ADDR_WIDTH-1:0]            bus_req_addr,
    output logic                             bus_wvalid,
    input  logic                             bus_wready,
    output logic [DATA_WIDTH-1:0]            bus_wdata,
    output logic                             bus_wlast,
    input  logic                             bus_rvalid,
    output logic                             bus_rready,
    input  logic [DATA_WIDTH-1:0]            bus_rdata,
    input  logic                             bus_rlast,
    input  logic                             bus_rerr
);
    localparam int OFF_BITS = $clog2(LINE_WORDS * DATA_WIDTH / 8);
    localparam int CNT_W    = $clog2(LINE_WORDS);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(LINE_WORDS - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    localparam logic [1:0] OP_RD  = 2'b00;
    localparam logic [1:0] OP_WR  = 2'b01;
    localparam logic [1:0] OP_INV = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_WDATA = 3'd2,
        S_RESP  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t state_q, state_d;
    logic [1:0]                           op_q, op_d;
    logic [ADDR_WIDTH-1:0]                addr_q, addr_d;
    logic [LINE_WORDS-1:0][DATA_WIDTH-1:0] wb_q, wb_d;
    logic [LINE_WORDS-1:0][DATA_WIDTH-1:0] rd_q, rd_d;
    logic [CNT_W-1:0]                     cnt_q, cnt_d;
    logic                                 err_q, err_d;

    logic       any_req_s;
    logic [1:0] sel_op_s;
    logic       req_hs_s, w_hs_s, r_hs_s;
    logic       w_last_s, r_final_s, r_end_s;
    logic       timeout_s;
    logic       unused_addr_s;

    // Request arbitration and handshake decode: writeback beats invalidate beats fill.
    always_comb begin
        any_req_s = write_req | invalid_req | read_req;
        if (write_req) begin
            sel_op_s = OP_WR;
        end else if (invalid_req) begin
            sel_op_s = OP_INV;
        end else begin
            sel_op_s = OP_RD;
        end
        req_hs_s  = (state_q == S_REQ)   && bus_req_ready;
        w_hs_s    = (state_q == S_WDATA) && bus_wready;
        r_hs_s    = (state_q == S_RESP)  && bus_rvalid;
        w_last_s  = (cnt_q == LAST_IDX);
        r_final_s = (op_q == OP_RD) ? (cnt_q == LAST_IDX) : 1'b1;
        r_end_s   = r_hs_s && (bus_rlast || r_final_s);
    end

    assign unused_addr_s = ^req_addr[OFF_BITS-1:0];

`ifdef BUS_TIMEOUT_EN
    logic [31:0] to_q, to_d;
    logic        active_s;

    // Wait counter: runs in bus-facing states, restarts on any handshake.
    always_comb begin
        active_s  = (state_q == S_REQ) || (state_q == S_WDATA) || (state_q == S_RESP);
        if (active_s && !(req_hs_s || w_hs_s || r_hs_s)) begin
            to_d = to_q + 32'd1;
        end else begin
            to_d = 32'd0;
        end
        timeout_s = active_s && !(req_hs_s || w_hs_s || r_hs_s) &&
                    (to_q == 32'(TIMEOUT_CYCLES - 1));
    end

    // Wait counter register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            to_q <= 32'd0;
        end else begin
            to_q <= to_d;
        end
    end
`else
    localparam int unused_timeout = TIMEOUT_CYCLES;
    assign timeout_s = 1'b0;
`endif

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  state_d = any_req_s ? S_REQ : S_IDLE;
            S_REQ:   begin
                if (req_hs_s) begin
                    state_d = (op_q == OP_WR) ? S_WDATA : S_RESP;
                end else begin
                    state_d = S_REQ;
                end
            end
            S_WDATA: state_d = (w_hs_s && w_last_s) ? S_RESP : S_WDATA;
            S_RESP:  state_d = r_end_s ? S_DONE : S_RESP;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (timeout_s) begin
            state_d = S_DONE;
        end else begin
            state_d = state_d;
        end
    end

    // Datapath next-state: request latch, beat counter, fill capture, error flag.
    always_comb begin
        op_d   = op_q;
        addr_d = addr_q;
        wb_d   = wb_q;
        rd_d   = rd_q;
        cnt_d  = cnt_q;
        err_d  = err_q;
        case (state_q)
            S_IDLE: begin
                if (any_req_s) begin
                    op_d   = sel_op_s;
                    addr_d = {req_addr[ADDR_WIDTH-1:OFF_BITS], {OFF_BITS{1'b0}}};
                    wb_d   = wb_line;
                    cnt_d  = {CNT_W{1'b0}};
                    err_d  = 1'b0;
                end else begin
                    op_d = op_q;
                end
            end
            S_WDATA: begin
                if (w_hs_s) begin
                    cnt_d = w_last_s ? {CNT_W{1'b0}} : cnt_q + CNT_ONE;
                end else begin
                    cnt_d = cnt_q;
                end
            end
            S_RESP: begin
                if (r_hs_s) begin
                    if (op_q == OP_RD) begin
                        rd_d[cnt_q] = bus_rdata;
                    end else begin
                        rd_d = rd_q;
                    end
                    if (bus_rerr || (bus_rlast != r_final_s)) begin
                        err_d = 1'b1;
                    end else begin
                        err_d = err_q;
                    end
                    cnt_d = r_end_s ? {CNT_W{1'b0}} : cnt_q + CNT_ONE;
                end else begin
                    cnt_d = cnt_q;
                end
            end
            S_DONE: begin
                err_d = 1'b0;
                cnt_d = {CNT_W{1'b0}};
            end
            default: begin
                cnt_d = cnt_q;
            end
        endcase
        if (timeout_s) begin
            err_d = 1'b1;
            cnt_d = {CNT_W{1'b0}};
        end else begin
            err_d = err_d;
        end
    end

    // Datapath registers; reset abandons any partial transaction.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_q   <= 2'b00;
            addr_q <= {ADDR_WIDTH{1'b0}};
            wb_q   <= {(LINE_WORDS*DATA_WIDTH){1'b0}};
            rd_q   <= {(LINE_WORDS*DATA_WIDTH){1'b0}};
            cnt_q  <= {CNT_W{1'b0}};
            err_q  <= 1'b0;
        end else begin
            op_q   <= op_d;
            addr_q <= addr_d;
            wb_q   <= wb_d;
            rd_q   <= rd_d;
            cnt_q  <= cnt_d;
            err_q  <= err_d;
        end
    end

    // Output decode from the registered state; everything is 0 outside its state.
    always_comb begin
        bus_req_valid = 1'b0;
        bus_req_op    = 2'b00;
        bus_req_addr  = {ADDR_WIDTH{1'b0}};
        bus_wvalid    = 1'b0;
        bus_wdata     = {DATA_WIDTH{1'b0}};
        bus_wlast     = 1'b0;
        bus_rready    = 1'b0;
        ace_ready     = 1'b0;
        resp_err      = 1'b0;
        case (state_q)
            S_REQ: begin
                bus_req_valid = 1'b1;
                bus_req_op    = op_q;
                bus_req_addr  = addr_q;
            end
            S_WDATA: begin
                bus_wvalid = 1'b1;
                bus_wdata  = wb_q[cnt_q];
                bus_wlast  = w_last_s;
            end
            S_RESP: begin
                bus_rready = 1'b1;
            end
            S_DONE: begin
                ace_ready = 1'b1;
                resp_err  = err_q;
            end
            default: begin
                ace_ready = 1'b0;
            end
        endcase
    end

    assign rd_line = rd_q;

endmodule

// File: doc/ace_bus_master.md
Name: ace_bus_master

Overview:
- Bus-side responder to the cache controller's request interface.
- Accepts level-held read_req / write_req / invalid_req, runs the matching line transaction on the interconnect, and pulses ace_ready at completion.
- Read transactions return the fetched line; writebacks stream the dirty line out; invalidate (CleanUnique) issues a dataless upgrade.
- Sits between the cache controller/datapath and the coherent interconnect port.

Parameters:
ADDR_WIDTH, 32, byte address width
DATA_WIDTH, 32, bus beat width in bits
LINE_WORDS, 4, beats per cache line (power of 2, >=2)
TIMEOUT_CYCLES, 255, response-wait limit (used only with the optional feature)

Ports:
clk  input  1  clock; one clock
reset  input  1  reset; asynchronous, active-low
read_req  input  1  line fill request, held high until ace_ready
write_req  input  1  line writeback request, held high until ace_ready
invalid_req  input  1  invalidate/upgrade request, held high until ace_ready
req_addr  input  ADDR_WIDTH  request byte address
wb_line  input  LINE_WORDS*DATA_WIDTH  dirty line for writeback; word i at [i*DATA_WIDTH +: DATA_WIDTH]
rd_line  output  LINE_WORDS*DATA_WIDTH  filled line; valid from ace_ready of a read
ace_ready  output  1  one-cycle completion pulse to cache controller
resp_err  output  1  error flag, valid only while ace_ready=1
bus_req_valid  output  1  request channel valid
bus_req_ready  input  1  request channel ready
bus_req_op  output  2  00 read, 01 write, 10 invalidate
bus_req_addr  output  ADDR_WIDTH  line-aligned address
bus_wvalid  output  1  write data valid
bus_wready  input  1  write data ready
bus_wdata  output  DATA_WIDTH  write beat
bus_wlast  output  1  final write beat
bus_rvalid  input  1  response beat valid
bus_rready  output  1  response beat ready
bus_rdata  input  DATA_WIDTH  response data
bus_rlast  input  1  final response beat
bus_rerr  input  1  response beat error

Behaviour:
- Reset (async, any state, including mid-transaction): state IDLE; all outputs 0; rd_line 0; beat counter 0; error flag 0. Partial bus transactions are abandoned.
- States: IDLE, REQ, WDATA, RESP, DONE.
- IDLE: requests are sampled only here.
  - Priority: write_req > invalid_req > read_req.
  - Latch op, wb_line and line-aligned address: low log2(LINE_WORDS*DATA_WIDTH/8) bits zeroed.
  - Next state REQ.
- REQ: bus_req_valid=1. bus_req_op and bus_req_addr are held stable until bus_req_ready.
  - On handshake: write goes to WDATA; read or invalidate goes to RESP.
- WDATA: bus_wvalid=1.
  - bus_wdata = latched word[cnt].
  - bus_wlast=1 when cnt==LINE_WORDS-1.
  - cnt increments on bus_wvalid&bus_wready.
  - After the last beat handshakes, go to RESP with cnt=0.
- RESP: bus_rready=1.
  - Read: expects LINE_WORDS beats; beat k is written to rd_line[k*DATA_WIDTH +: DATA_WIDTH].
  - Write or invalidate: expects 1 beat; bus_rdata is ignored.
  - Any beat with bus_rerr=1 sets the error flag (sticky for the transaction).
  - bus_rlast on a non-final beat, or missing on the final expected beat, sets the error flag.
  - RESP ends on the first of: bus_rlast, or the final expected beat. Extra beats are never consumed.
- DONE: ace_ready=1 and resp_err=error flag, for exactly one cycle. Clear the error flag, then go to IDLE. Requests are ignored in DONE.
- Latency at zero bus wait, measured from the IDLE sample cycle (cycle 0) to the ace_ready cycle:
  - read: LINE_WORDS+2
  - write: LINE_WORDS+3
  - invalidate: 3
- rd_line changes only on read beats; it holds its value across write and invalidate transactions.
- read_req+write_req high together (writeback-then-fill): the writeback completes first; the read is sampled on the next IDLE cycle.
- No request high in IDLE: stays in IDLE, all bus valids 0.

Optional Feature:
- Macro: BUS_TIMEOUT_EN.
- Defined:
  - A counter runs while in REQ, WDATA or RESP and clears on every handshake.
  - When it reaches TIMEOUT_CYCLES, drop all valids/readies and go to DONE with resp_err=1.
- Undefined: no counter; the block waits indefinitely; TIMEOUT_CYCLES is unused.

Test Plan:
- Read fill:
  - Stimulus: read_req=1, req_addr=0x1234, zero-wait bus returning 0xA0..0xA3, rlast on beat 3.
  - Required: bus_req_addr=0x1230, op=00; ace_ready 6 cycles after sample; rd_line={0xA3,0xA2,0xA1,0xA0}; resp_err=0.
- Writeback with backpressure:
  - Stimulus: write_req=1, wb_line words 0x10..0x13, bus_wready low every other cycle.
  - Required: beats 0x10,0x11,0x12,0x13 in order; wlast only on 0x13; single response consumed; ace_ready pulse of exactly 1 cycle.
- Simultaneous requests and invalidate:
  - Stimulus: read_req and write_req both high.
  - Required: op=01 transaction first; op=00 follows after the IDLE cycle.
  - Stimulus: invalid_req alone.
  - Required: op=10; ace_ready 3 cycles after sample.
- Error paths:
  - bus_rerr=1 on read beat 2 -> resp_err=1 with ace_ready.
  - bus_rlast on beat 1 -> RESP ends early, resp_err=1.
- Reset mid-WDATA:
  - Stimulus: reset low after beat 1.
  - Required: all outputs 0 immediately, state IDLE; a following read_req completes normally.
- Timeout (BUS_TIMEOUT_EN, TIMEOUT_CYCLES=8):
  - Stimulus: bus_req_ready held 0.
  - Required: ace_ready with resp_err=1 after 8 wait cycles, bus_req_valid deasserted.
